// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

package fetch_pkg;

  localparam int unsigned DEF_ADDR_W = `COMMON_WIDTH;
  localparam int unsigned DEF_DATA_W = `COMMON_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries; clear has priority over push/pop.
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Effective push/pop; an empty pop is ignored, and clear overrides both.
  always_comb begin
    do_push = push_i && !full_o && !clear_i;
    do_pop  = pop_i && !empty_o && !clear_i;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents are only visible through the empty-gated head mux.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: consumes pc_addr, keeps one request outstanding to
// instruction memory, buffers returned words with their PC, and presents them to decode.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              drop_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  logic              push, pop, credit, capture;
  logic [CNT_W:0]    occ_next;

  // Credit counts the FIFO as it will be after this cycle's pop and push, so a word
  // landing on the same edge as a new capture is already accounted for.
  always_comb begin
    pop      = !fifo_empty && inst_ready;
    push     = (state_q == WAIT) && imem_ack && !drop_q && !flush && !fifo_full;
    occ_next = (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop) + (CNT_W+1)'(push);
    credit   = occ_next < (CNT_W+1)'(BUF_DEPTH);
    capture  = credit && !flush && ((state_q == IDLE) || imem_ack);
  end

  assign stall      = !rst_n || !capture;
  assign imem_req   = req_q;
  assign imem_addr  = req_addr_q;
  assign inst_valid = !fifo_empty;
  assign {inst_pc, inst_data} = fifo_head;

  // Request FSM: capture PC, wait for ack, chain back-to-back when credit allows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            req_addr_q <= pc_addr;
            req_q      <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            drop_q <= 1'b0;
            if (capture) begin
              req_addr_q <= pc_addr;
            end else begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (push),
    .wdata_i ({req_addr_q, imem_rdata}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand sequences, then random traffic
// checked against a queue-based reference model.
module tb_inst_fetch;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_addr;
  logic          stall;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .BUF_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[13];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          pend, pdrop;
  logic [31:0] paddr;

  initial begin
    //            pc          fl ack rdata          rdy stl req addr         vld pc           data
    tbl[0]  = '{32'h00, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
    tbl[1]  = '{32'h04, 1'b0, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0};
    tbl[2]  = '{32'h08, 1'b0, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 32'hA000_0000};
    tbl[3]  = '{32'h0C, 1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'hA000_0001};
    tbl[4]  = '{32'h0C, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'hA000_0001};
    tbl[5]  = '{32'h0C, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 32'hA000_0001};
    tbl[6]  = '{32'h10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'hA000_0002};
    tbl[7]  = '{32'h10, 1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h00, 32'h0};
    tbl[8]  = '{32'h14, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'hA000_0003};
    tbl[9]  = '{32'h20, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00, 32'h0};
    tbl[10] = '{32'h24, 1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00, 32'h0};
    tbl[11] = '{32'h28, 1'b1, 1'b1, 32'hB000_0001, 1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h20, 32'hB000_0000};
    tbl[12] = '{32'h30, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};

    rst_n = 1'b0; pc_addr = '0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    #2;
    chk("rst_stall", stall, 1);
    chk("rst_req",   imem_req, 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc",    inst_pc, 0);
    chk("rst_data",  inst_data, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed table: streaming, backpressure, flush in flight, flush+ack+pop.
    for (int i = 0; i < 13; i++) begin
      pc_addr = tbl[i].pc; flush = tbl[i].flush; imem_ack = tbl[i].ack;
      imem_rdata = tbl[i].rdata; inst_ready = tbl[i].ready;
      #1;
      chk($sformatf("t%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("t%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), inst_valid, tbl[i].e_valid);
      chk($sformatf("t%0d_ipc", i), inst_pc, tbl[i].e_pc);
      chk($sformatf("t%0d_idata", i), inst_data, tbl[i].e_data);
      @(negedge clk);
    end

    // Reset asserted mid-WAIT (request to 0x30 outstanding).
    flush = 1'b0; imem_ack = 1'b0;
    chk("midwait_req_before", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_req",   imem_req, 0);
    chk("midwait_rst_valid", inst_valid, 0);
    chk("midwait_rst_stall", stall, 1);
    chk("midwait_rst_addr",  imem_addr, 0);
    @(negedge clk);

    // Slow memory: ack arrives after three waiting cycles.
    rst_n = 1'b1; pc_addr = 32'h40; inst_ready = 1'b0;
    #1;
    chk("slow_capture_stall", stall, 0);
    @(negedge clk);
    pc_addr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("slow_req%0d", k), imem_req, 1);
      chk($sformatf("slow_addr%0d", k), imem_addr, 32'h40);
      chk($sformatf("slow_stall%0d", k), stall, 1);
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = 32'h00C0_FFEE;
    #1;
    chk("slow_ack_stall", stall, 0);
    chk("slow_ack_addr", imem_addr, 32'h40);
    @(negedge clk);
    imem_ack = 1'b0; pc_addr = 32'h48;
    #1;
    chk("slow_valid", inst_valid, 1);
    chk("slow_ipc",   inst_pc, 32'h40);
    chk("slow_idata", inst_data, 32'h00C0_FFEE);
    chk("slow_next_addr", imem_addr, 32'h44);
    @(negedge clk);

    // Re-synchronise with an empty model before random traffic.
    rst_n = 1'b0;
    mq.delete(); pend = 0; pdrop = 0; paddr = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      int  occ;
      bit  cap, do_pop, do_push;
      flush      = ($urandom_range(0, 11) == 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      imem_ack   = pend && ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      pc_addr    = $urandom;
      #1;
      do_pop  = inst_ready && (mq.size() > 0);
      do_push = pend && imem_ack && !pdrop && !flush;
      occ     = mq.size() - int'(do_pop) + int'(do_push);
      cap     = !flush && (!pend || imem_ack) && (occ < D);

      chk("rnd_stall", stall, !cap);
      chk("rnd_req", imem_req, pend);
      if (pend) chk("rnd_addr", imem_addr, paddr);
      chk("rnd_valid", inst_valid, mq.size() > 0);
      chk("rnd_ipc",   inst_pc,   (mq.size() > 0) ? mq[0].pc   : 32'h0);
      chk("rnd_idata", inst_data, (mq.size() > 0) ? mq[0].inst : 32'h0);

      @(posedge clk);
      if (flush) begin
        mq.delete();
        if (pend && !imem_ack) pdrop = 1;
        else begin pend = 0; pdrop = 0; end
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{paddr, imem_rdata});
        if (pend && imem_ack) begin pend = 0; pdrop = 0; end
        if (cap) begin pend = 1; paddr = pc_addr; end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
